// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vram_pkg
// Purpose  : Shared FSM state types and default depth for the VRAM buffer.
// Revision : 1.0 - initial release
// ============================================================================
package vram_pkg;

   localparam int VRAM_DEFAULT_DEPTH = 2400;

   typedef enum logic [0:0] {
      W_IDLE   = 1'b0,
      W_COMMIT = 1'b1
   } wr_state_t;

   typedef enum logic [0:0] {
      R_IDLE  = 1'b0,
      R_FETCH = 1'b1
   } rd_state_t;

   typedef enum logic [0:0] {
      T_IDLE  = 1'b0,
      T_CLEAR = 1'b1
   } top_state_t;

endpackage
`default_nettype wire

// File: rtl/request_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : request_edge_detect
// Purpose  : Rising-edge pulse from a request level; history resets high so a
//            request held through reset never fires.
// Revision : 1.0 - initial release
// ============================================================================
module request_edge_detect (
   input  logic i_Clk,
   input  logic i_Reset,
   input  logic i_Req,
   output logic o_Edge
);

   logic r_prev;

   always_ff @(posedge i_Clk) begin
      if (i_Reset) r_prev <= 1'b1;
      else         r_prev <= i_Req;
   end

   assign o_Edge = i_Req & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/vram_handshake_buffer.sv
`default_nettype none
// ============================================================================
// Module   : vram_handshake_buffer
// Purpose  : Dual-channel video RAM with req/ready handshakes, bounds checks,
//            write-first collision bypass. Optional clear engine: VRAM_CLEAR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vram_handshake_buffer
   import vram_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = VRAM_DEFAULT_DEPTH
) (
   input  logic                  i_Clk,
   input  logic                  i_Reset,
   input  logic                  i_Wr_Req,
   input  logic [ADDR_WIDTH-1:0] i_Wr_Addr,
   input  logic [DATA_WIDTH-1:0] i_Wr_Data,
   output logic                  o_Wr_Ready,
   output logic                  o_Wr_Done,
   output logic                  o_Wr_Err,
   input  logic                  i_Rd_Req,
   input  logic [ADDR_WIDTH-1:0] i_Rd_Addr,
   output logic                  o_Rd_Ready,
   output logic                  o_Rd_Valid,
   output logic [ADDR_WIDTH-1:0] o_Rd_Addr,
   output logic [DATA_WIDTH-1:0] o_Rd_Data,
   output logic                  o_Rd_Err,
   input  logic                  i_Clear,
   output logic                  o_Clear_Done
);

   if (DEPTH > (1 << ADDR_WIDTH)) begin : g_depth_check
      $error("vram_handshake_buffer: DEPTH exceeds 2**ADDR_WIDTH");
   end

   localparam logic [ADDR_WIDTH:0]   c_DEPTH     = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   logic w_wr_edge, w_rd_edge, w_clr_edge;

   request_edge_detect u_wr_edge (.i_Clk(i_Clk), .i_Reset(i_Reset), .i_Req(i_Wr_Req), .o_Edge(w_wr_edge));
   request_edge_detect u_rd_edge (.i_Clk(i_Clk), .i_Reset(i_Reset), .i_Req(i_Rd_Req), .o_Edge(w_rd_edge));
   request_edge_detect u_cl_edge (.i_Clk(i_Clk), .i_Reset(i_Reset), .i_Req(i_Clear),  .o_Edge(w_clr_edge));

   wr_state_t r_wr_state, w_wr_next;
   rd_state_t r_rd_state, w_rd_next;
   logic      w_clr_busy;
   logic      w_wr_accept, w_rd_accept, w_wr_commit, w_rd_fetch;

   logic [ADDR_WIDTH-1:0] r_wr_addr, r_rd_addr;
   logic [DATA_WIDTH-1:0] r_wr_data;
   logic                  w_wr_in_range, w_rd_in_range, w_collide;

   logic                  r_wr_done, r_wr_err, r_rd_valid, r_rd_err;
   logic [ADDR_WIDTH-1:0] r_rd_addr_out;
   logic [DATA_WIDTH-1:0] r_rd_data;

   logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
   logic                  w_mem_we;
   logic [ADDR_WIDTH-1:0] w_mem_addr;
   logic [DATA_WIDTH-1:0] w_mem_wdata;

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_wr_state <= W_IDLE;
         r_rd_state <= R_IDLE;
      end else begin
         r_wr_state <= w_wr_next;
         r_rd_state <= w_rd_next;
      end
   end

   always_comb begin
      w_wr_next   = r_wr_state;
      w_rd_next   = r_rd_state;
      o_Wr_Ready  = (r_wr_state == W_IDLE) && !w_clr_busy;
      o_Rd_Ready  = (r_rd_state == R_IDLE) && !w_clr_busy;
      w_wr_accept = w_wr_edge && o_Wr_Ready;
      w_rd_accept = w_rd_edge && o_Rd_Ready;
      w_wr_commit = (r_wr_state == W_COMMIT);
      w_rd_fetch  = (r_rd_state == R_FETCH);
      case (r_wr_state)
         W_IDLE:   if (w_wr_accept) w_wr_next = W_COMMIT;
         W_COMMIT: w_wr_next = W_IDLE;
         default:  w_wr_next = W_IDLE;
      endcase
      case (r_rd_state)
         R_IDLE:   if (w_rd_accept) w_rd_next = R_FETCH;
         R_FETCH:  w_rd_next = R_IDLE;
         default:  w_rd_next = R_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (w_wr_accept) begin
         r_wr_addr <= i_Wr_Addr;
         r_wr_data <= i_Wr_Data;
      end
      if (w_rd_accept) r_rd_addr <= i_Rd_Addr;
   end

   assign w_wr_in_range = ({1'b0, r_wr_addr} < c_DEPTH);
   assign w_rd_in_range = ({1'b0, r_rd_addr} < c_DEPTH);
   // Same-cycle commit and fetch on one cell: return the data being written.
   assign w_collide     = w_wr_commit && w_wr_in_range && (r_wr_addr == r_rd_addr);

`ifdef VRAM_CLEAR_EN
   top_state_t            r_top_state, w_top_next;
   logic [ADDR_WIDTH-1:0] r_clr_addr;
   logic                  r_clr_done;

   always_ff @(posedge i_Clk) begin
      if (i_Reset) r_top_state <= T_IDLE;
      else         r_top_state <= w_top_next;
   end

   // A clear competing with a same-cycle channel acceptance loses.
   always_comb begin
      w_top_next = r_top_state;
      w_clr_busy = (r_top_state == T_CLEAR);
      case (r_top_state)
         T_IDLE:  if (w_clr_edge && r_wr_state == W_IDLE && r_rd_state == R_IDLE
                      && !w_wr_accept && !w_rd_accept) w_top_next = T_CLEAR;
         T_CLEAR: if (r_clr_addr == c_LAST_ADDR) w_top_next = T_IDLE;
         default: w_top_next = T_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_clr_addr <= '0;
         r_clr_done <= 1'b0;
      end else begin
         r_clr_done <= w_clr_busy && (r_clr_addr == c_LAST_ADDR);
         if (w_clr_busy && r_clr_addr != c_LAST_ADDR) r_clr_addr <= r_clr_addr + 1'b1;
         else                                         r_clr_addr <= '0;
      end
   end

   assign o_Clear_Done = r_clr_done;
`else
   logic w_unused_clear;
   assign w_unused_clear = w_clr_edge;
   assign w_clr_busy     = 1'b0;
   assign o_Clear_Done   = 1'b0;
`endif

   always_comb begin
      w_mem_we    = w_wr_commit && w_wr_in_range;
      w_mem_addr  = r_wr_addr;
      w_mem_wdata = r_wr_data;
`ifdef VRAM_CLEAR_EN
      if (w_clr_busy) begin
         w_mem_we    = 1'b1;
         w_mem_addr  = r_clr_addr;
         w_mem_wdata = '0;
      end
`endif
   end

   always_ff @(posedge i_Clk) begin
      if (w_mem_we && !i_Reset) r_mem[w_mem_addr] <= w_mem_wdata;
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_wr_done     <= 1'b0;
         r_wr_err      <= 1'b0;
         r_rd_valid    <= 1'b0;
         r_rd_err      <= 1'b0;
         r_rd_data     <= '0;
         r_rd_addr_out <= '0;
      end else begin
         r_wr_done  <= w_wr_commit;
         r_wr_err   <= w_wr_commit && !w_wr_in_range;
         r_rd_valid <= w_rd_fetch;
         r_rd_err   <= w_rd_fetch && !w_rd_in_range;
         if (w_rd_fetch) begin
            r_rd_addr_out <= r_rd_addr;
            if (!w_rd_in_range) r_rd_data <= '0;
            else if (w_collide) r_rd_data <= r_wr_data;
            else                r_rd_data <= r_mem[r_rd_addr];
         end
      end
   end

   assign o_Wr_Done  = r_wr_done;
   assign o_Wr_Err   = r_wr_err;
   assign o_Rd_Valid = r_rd_valid;
   assign o_Rd_Err   = r_rd_err;
   assign o_Rd_Data  = r_rd_data;
   assign o_Rd_Addr  = r_rd_addr_out;

endmodule
`default_nettype wire

// File: tb/tb_vram_handshake_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_handshake_buffer
// Purpose  : Transaction-level reference model plus directed and random traffic
//            for vram_handshake_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_handshake_buffer;

   localparam int AW    = 12;
   localparam int DW    = 8;
   localparam int DEPTH = 2400;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_req = 1'b0, rd_req = 1'b0, clr_req = 1'b0;
   logic [AW-1:0] wr_addr = '0, rd_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_ready, wr_done, wr_err, rd_ready, rd_valid, rd_err, clr_done;
   logic [AW-1:0] rd_addr_o;
   logic [DW-1:0] rd_data;

   vram_handshake_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .i_Clk(clk), .i_Reset(rst),
      .i_Wr_Req(wr_req), .i_Wr_Addr(wr_addr), .i_Wr_Data(wr_data),
      .o_Wr_Ready(wr_ready), .o_Wr_Done(wr_done), .o_Wr_Err(wr_err),
      .i_Rd_Req(rd_req), .i_Rd_Addr(rd_addr),
      .o_Rd_Ready(rd_ready), .o_Rd_Valid(rd_valid), .o_Rd_Addr(rd_addr_o),
      .o_Rd_Data(rd_data), .o_Rd_Err(rd_err),
      .i_Clear(clr_req), .o_Clear_Done(clr_done)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one outstanding transaction per channel, memory as a sparse map.
   logic [DW-1:0] m_mem [int];
   bit      m_prev_w = 1, m_prev_r = 1, m_prev_c = 1;
   bit      m_wr_pend = 0, m_rd_pend = 0;
   int      m_wa = 0, m_ra = 0, m_clear_left = 0;
   logic [DW-1:0] m_wd = '0;
   bit      e_wr_ready = 1, e_rd_ready = 1, e_wr_done = 0, e_wr_err = 0;
   bit      e_rd_valid = 0, e_rd_err = 0, e_rd_known = 1, e_clr_done = 0;
   logic [DW-1:0] e_rd_data = '0;
   int      e_rd_addr = 0;

   always @(posedge clk) begin
      bit w_rdy, r_rdy, w_edge, r_edge, c_edge, w_acc, r_acc, old_wp, old_rp;
      int old_cl;
      if (rst) begin
         m_prev_w = 1; m_prev_r = 1; m_prev_c = 1;
         m_wr_pend = 0; m_rd_pend = 0; m_clear_left = 0;
         e_wr_done = 0; e_wr_err = 0; e_rd_valid = 0; e_rd_err = 0;
         e_rd_data = '0; e_rd_addr = 0; e_rd_known = 1; e_clr_done = 0;
      end else begin
         old_wp = m_wr_pend; old_rp = m_rd_pend; old_cl = m_clear_left;
         w_rdy  = !old_wp && old_cl == 0;
         r_rdy  = !old_rp && old_cl == 0;
         w_edge = wr_req && !m_prev_w;
         r_edge = rd_req && !m_prev_r;
         c_edge = clr_req && !m_prev_c;

         e_wr_done = old_wp;
         e_wr_err  = old_wp && (m_wa >= DEPTH);
         if (old_wp && m_wa < DEPTH) m_mem[m_wa] = m_wd;

         e_clr_done = 0;
         if (old_cl > 0) begin
            m_mem[DEPTH - old_cl] = '0;
            m_clear_left = old_cl - 1;
            e_clr_done = (m_clear_left == 0);
         end

         e_rd_valid = old_rp;
         e_rd_err   = old_rp && (m_ra >= DEPTH);
         if (old_rp) begin
            e_rd_addr = m_ra;
            if (m_ra >= DEPTH) begin
               e_rd_data = '0; e_rd_known = 1;
            end else if (m_mem.exists(m_ra)) begin
               e_rd_data = m_mem[m_ra]; e_rd_known = 1;
            end else begin
               e_rd_known = 0;
            end
         end

         w_acc = w_edge && w_rdy;
         r_acc = r_edge && r_rdy;
         m_wr_pend = w_acc;
         m_rd_pend = r_acc;
         if (w_acc) begin m_wa = int'(wr_addr); m_wd = wr_data; end
         if (r_acc) m_ra = int'(rd_addr);
`ifdef VRAM_CLEAR_EN
         if (c_edge && old_cl == 0 && !old_wp && !old_rp && !w_acc && !r_acc)
            m_clear_left = DEPTH;
`endif
         m_prev_w = wr_req; m_prev_r = rd_req; m_prev_c = clr_req;
      end
      e_wr_ready = !m_wr_pend && m_clear_left == 0;
      e_rd_ready = !m_rd_pend && m_clear_left == 0;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("wr_ready", wr_ready, e_wr_ready);
         chk("rd_ready", rd_ready, e_rd_ready);
         chk("wr_done",  wr_done,  e_wr_done);
         chk("rd_valid", rd_valid, e_rd_valid);
         chk("clr_done", clr_done, e_clr_done);
         chk("rd_addr",  rd_addr_o, e_rd_addr);
         if (e_wr_done)  chk("wr_err", wr_err, e_wr_err);
         if (e_rd_valid) chk("rd_err", rd_err, e_rd_err);
         if (e_rd_known) chk("rd_data", rd_data, e_rd_data);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_wr(input int a, input int d);
      wr_req = 1; wr_addr = AW'(a); wr_data = DW'(d);
      tick();
      wr_req = 0;
      tick();
   endtask

   task automatic do_rd(input int a);
      rd_req = 1; rd_addr = AW'(a);
      tick();
      rd_req = 0;
      tick();
   endtask

   function automatic logic [AW-1:0] pick_addr();
      case ($urandom_range(0, 2))
         0:       return AW'($urandom_range(0, 7));
         1:       return AW'($urandom_range(2396, 2403));
         default: return AW'($urandom_range(0, 4095));
      endcase
   endfunction

   initial begin
      int dones;
      rst = 1;
      tick(); tick();
      chk_en = 1;
      rst = 0;
      tick();
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_rd_ready", rd_ready, 1);
      chk("rst_rd_data",  rd_data, 0);
      chk("rst_rd_addr",  rd_addr_o, 0);
      chk("rst_clr_done", clr_done, 0);

      do_wr(5, 8'h41);
      chk("t1_wr_done", wr_done, 1);
      chk("t1_wr_err",  wr_err, 0);
      do_rd(5);
      chk("t1_rd_valid", rd_valid, 1);
      chk("t1_rd_data",  rd_data, 8'h41);
      chk("t1_rd_addr",  rd_addr_o, 5);
      chk("t1_rd_err",   rd_err, 0);
      chk("t1_model_data", e_rd_data, 8'h41);

      do_wr(2399, 8'h33);
      do_wr(2400, 8'h99);
      chk("t2_wr_err", wr_err, 1);
      do_rd(2400);
      chk("t2_rd_data", rd_data, 0);
      chk("t2_rd_err",  rd_err, 1);
      do_rd(2399);
      chk("t2_keep_2399", rd_data, 8'h33);

      do_wr(10, 8'h11);
      wr_req = 1; wr_addr = 10; wr_data = 8'h7E;
      rd_req = 1; rd_addr = 10;
      tick();
      wr_req = 0; rd_req = 0;
      tick();
      chk("t3_bypass_valid", rd_valid, 1);
      chk("t3_bypass_done",  wr_done, 1);
      chk("t3_bypass_data",  rd_data, 8'h7E);

      rst = 1; wr_req = 1; wr_addr = 20; wr_data = 8'h55;
      tick(); tick();
      rst = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t4_no_write_after_rst", wr_done, 0);
      end
      wr_req = 0;
      tick();
      dones = 0;
      wr_req = 1; wr_addr = 21; wr_data = 8'h66;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (wr_done) dones++;
      end
      wr_req = 0;
      chk("t4_single_done", dones, 1);
      do_rd(21);
      chk("t4_rd_21", rd_data, 8'h66);

`ifdef VRAM_CLEAR_EN
      begin
         int low, guard;
         for (int a = 0; a < 4; a++) do_wr(a, 8'hFF);
         clr_req = 1;
         tick();
         clr_req = 0;
         low = 0; guard = 0;
         while (!clr_done && guard < 3000) begin
            if (!wr_ready && !rd_ready) low++;
            tick();
            guard++;
         end
         chk("t5_clear_done", clr_done, 1);
         chk("t5_low_cycles", low, DEPTH);
         tick();
         do_rd(3);
         chk("t5_rd_cleared", rd_data, 0);
      end
`endif

      for (int i = 0; i < 4000; i++) begin
         wr_req  = 1'($urandom_range(0, 1));
         rd_req  = 1'($urandom_range(0, 1));
         wr_addr = pick_addr();
         wr_data = DW'($urandom);
         rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : pick_addr();
         tick();
      end
      wr_req = 0; rd_req = 0;
      tick(); tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vram_handshake_buffer.md
# vram_handshake_buffer

Parametrised dual-channel video RAM with independent write and read request/ready handshakes, address bounds checking, and read/write collision bypass. It sits between the UART/remote command decoder (writer) and the VGA character/pixel fetcher (reader) in the remote-buffer display path. It replaces the fixed 2400-entry store with configurable width and depth, completion pulses, error flags and an optional hardware clear engine.

## Interface
- ADDR_WIDTH, 12, address bus width
- DATA_WIDTH, 8, data word width
- DEPTH, 2400, number of valid entries; must be ≤ 2**ADDR_WIDTH (elaboration error otherwise)

Ports:
- i_Clk  in  1  sole clock; all logic on rising edge
- i_Reset  in  1  synchronous, active-high reset
- i_Wr_Req  in  1  write request, level or pulse; rising edge triggers
- i_Wr_Addr  in  ADDR_WIDTH  write address, sampled on accepted edge
- i_Wr_Data  in  DATA_WIDTH  write data, sampled on accepted edge
- o_Wr_Ready  out  1  write channel idle, edge will be accepted
- o_Wr_Done  out  1  one-cycle pulse, write completed
- o_Wr_Err  out  1  valid with o_Wr_Done; address ≥ DEPTH, memory untouched
- i_Rd_Req  in  1  read request; rising edge triggers
- i_Rd_Addr  in  ADDR_WIDTH  read address, sampled on accepted edge
- o_Rd_Ready  out  1  read channel idle
- o_Rd_Valid  out  1  one-cycle pulse, o_Rd_Data/o_Rd_Addr valid
- o_Rd_Addr  out  ADDR_WIDTH  address belonging to o_Rd_Data
- o_Rd_Data  out  DATA_WIDTH  read data; 0 when out of range
- o_Rd_Err  out  1  valid with o_Rd_Valid; address ≥ DEPTH
- i_Clear  in  1  clear request, rising edge (used only with VRAM_CLEAR_EN)
- o_Clear_Done  out  1  one-cycle pulse at end of clear

## Operation
- Each request input passes through an edge detector; the previous-level register resets to 1, so a request held high through reset does not fire.
- Edge accepted only when the matching ready is 1; edges arriving while not ready are dropped (requester must re-raise).
- Write FSM: W_IDLE → (accepted edge) W_COMMIT → W_IDLE. W_COMMIT writes memory if addr < DEPTH and pulses o_Wr_Done; o_Wr_Err = (addr ≥ DEPTH).
- Read FSM: R_IDLE → (accepted edge) R_FETCH → R_IDLE. R_FETCH registers memory data (or 0 when out of range), the captured address and the error flag, and pulses o_Rd_Valid.
- Collision: W_COMMIT and R_FETCH in the same cycle at the same in-range address → o_Rd_Data returns the new write data (write-first bypass).
- o_Rd_Data/o_Rd_Addr hold their last value until the next o_Rd_Valid.
- Reset: o_Wr_Ready=1, o_Rd_Ready=1, o_Wr_Done=0, o_Wr_Err=0, o_Rd_Valid=0, o_Rd_Err=0, o_Rd_Data=0, o_Rd_Addr=0, o_Clear_Done=0; FSMs to idle; memory contents not reset. Reset during W_COMMIT aborts the write (memory may or may not be updated; no Done pulse).

## Timing
- Edge sampled at clock edge N → ready low after N → commit/fetch at N+1 → Done/Valid high for cycle N+1..N+2, ready high again after N+1.
- Minimum spacing between accepted requests per channel: 2 cycles; both channels run concurrently and independently.
- Read latency from accepted edge to o_Rd_Valid: 1 cycle.

## Configuration
- VRAM_CLEAR_EN defined: top FSM IDLE → CLEAR on an i_Clear edge when both channels are idle; writes 0 to addresses 0..DEPTH-1, one per cycle (DEPTH cycles); both readies held 0 throughout; o_Clear_Done pulses on the cycle after the last address; returns to IDLE. An i_Clear edge while either channel is busy is dropped. Reset mid-clear aborts, leaving memory partially cleared.
- Undefined: i_Clear is ignored, o_Clear_Done is tied 0, and there is no clear counter or CLEAR state.

## Structure
- Package vram_pkg: write/read/top FSM state enums, VRAM_DEFAULT_DEPTH = 2400.
- Sub-module request_edge_detect (reset-to-1 previous register, rising-edge pulse output) is instantiated three times.
- Memory is inferred as a simple dual-port block RAM.

## Test plan
- Write 0x41 to address 5, then read 5 → o_Wr_Done at N+1 with Err=0; o_Rd_Valid with o_Rd_Data=0x41, o_Rd_Addr=5, Err=0.
- Write to address 2400 (DEPTH=2400), then read 2400 → o_Wr_Err=1; o_Rd_Data=0, o_Rd_Err=1; address 2399 unchanged.
- Write 0x7E to address 10 and a read of address 10 with an aligned commit/fetch cycle → o_Rd_Data=0x7E (bypass).
- Hold i_Wr_Req high across reset release → no write occurs; a second i_Wr_Req edge while o_Wr_Ready=0 → dropped, exactly one o_Wr_Done.
- With VRAM_CLEAR_EN, fill addresses 0..3 with 0xFF and pulse i_Clear → readies low for 2400 cycles, then o_Clear_Done; reading address 3 returns 0.
